instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, word-aligned PC loaded on reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, max wait cycles for imem_ack; used only when FETCH_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  word-aligned fetch address; SHALL equal pc.
REQ-007 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 stall  input  1  downstream cannot accept a new instruction.
REQ-010 npc_op  input  2  next-PC select: 0 SEQ, 1 BRANCH, 2 JUMP, 3 JR.
REQ-011 branch_taken  input  1  branch condition result, used only with BRANCH.
REQ-012 ext_imm  input  32  sign-extended immediate from the extend stage.
REQ-013 jr_target  input  32  register jump target.
REQ-014 pc  output  32  address of the instruction held in instr.
REQ-015 instr  output  32  instruction register.
REQ-016 instr_valid  output  1  instr/pc valid for decode.
REQ-017 imm16  output  16  instr[15:0], feeds the extend stage.
REQ-018 fetch_err  output  1  sticky fetch timeout flag; constant 0 without FETCH_TIMEOUT_EN.

Function
REQ-019 FSM states SHALL be FETCH and HOLD.
REQ-020 FETCH: imem_req=1, instr_valid=0; on imem_ack, instr<=imem_rdata, go to HOLD next cycle.
REQ-021 imem_ack SHALL be ignored while imem_req=0.
REQ-022 HOLD: imem_req=0, instr_valid=1; instr and pc SHALL stay stable while stall=1.
REQ-023 HOLD with stall=0: pc<=next PC, go to FETCH; instruction handed off on that edge.
REQ-024 Next PC for SEQ, or BRANCH with branch_taken=0: pc+4.
REQ-025 Next PC for BRANCH with branch_taken=1: pc+4+(ext_imm<<2).
REQ-026 Next PC for JUMP: {pc+4 [31:28], instr[25:0], 2'b00}.
REQ-027 Next PC for JR: {jr_target[31:2], 2'b00}; low two bits forced to zero.
REQ-028 All PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-029 Fetch-to-valid latency SHALL be one cycle after the ack edge; minimum SHALL be 2 cycles per instruction.
REQ-030 imm16 SHALL always equal instr[15:0] combinationally.

Reset
REQ-031 With rst=1 at an edge: state FETCH, pc=RESET_PC, instr=0, instr_valid=0, fetch_err=0, timeout counter 0.
REQ-032 During reset, imem_req SHALL be 1 and imem_addr SHALL be RESET_PC (FETCH state outputs).
REQ-033 Reset mid-fetch SHALL discard any ack in that cycle; fetch restarts at RESET_PC.
REQ-034 rst SHALL override stall, imem_ack, and npc_op.

Configuration
REQ-035 Macro FETCH_TIMEOUT_EN, when defined: an 8+ bit counter SHALL count consecutive FETCH cycles without imem_ack.
REQ-036 With FETCH_TIMEOUT_EN, on reaching TIMEOUT_CYCLES: fetch_err<=1, sticky until reset; imem_req stays asserted.
REQ-037 With FETCH_TIMEOUT_EN, the counter SHALL clear on each ack.
REQ-038 Without FETCH_TIMEOUT_EN: no counter, fetch_err tied 0, and the unit SHALL wait indefinitely.

Verification
REQ-039 Reset, then ack in 1st FETCH cycle with rdata=32'h2008_0005 -> next cycle instr_valid=1, pc=32'h3000, imm16=16'h0005.
REQ-040 HOLD, stall=1 for 3 cycles, then stall=0 with SEQ -> instr stable 3 cycles, then pc=32'h3004, imem_req=1.
REQ-041 pc=32'h3008, BRANCH, taken, ext_imm=32'hFFFF_FFFE -> next fetch address 32'h3004; not taken -> 32'h300C.
REQ-042 JUMP with instr[25:0]=26'h0000C10 at pc=32'h3000 -> 32'h0000_3040; JR with jr_target=32'h1237 -> 32'h1234.
REQ-043 With FETCH_TIMEOUT_EN, no ack for 255 cycles -> fetch_err=1; late ack loads instr, fetch_err remains 1 until rst.
REQ-044 rst during FETCH with concurrent ack -> instr=0, instr_valid=0, imem_addr=RESET_PC next cycle.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: two-state (FETCH/HOLD) instruction fetch stage with
// next-PC selection for sequential, branch, jump and register-jump flow.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   imem_req          read request, asserted in FETCH
//   imem_addr         fetch address (always equal to pc)
//   imem_ack          read data valid this cycle (ignored outside FETCH)
//   imem_rdata        fetched instruction word
//   stall             downstream not ready; holds instr/pc in HOLD
//   npc_op            next-PC select: 0 SEQ, 1 BRANCH, 2 JUMP, 3 JR
//   branch_taken      branch condition, used with BRANCH only
//   ext_imm           sign-extended immediate (word offset for branches)
//   jr_target         register jump target
//   pc                address of the instruction held in instr
//   instr             instruction register
//   instr_valid       instr/pc valid for decode (HOLD state)
//   imm16             instr[15:0], feeds the extend stage
//   fetch_err         sticky fetch timeout flag
//
// Build option: define FETCH_TIMEOUT_EN to enable the imem_ack timeout
// counter and fetch_err. Without it fetch_err is 0 and FETCH waits forever.

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_3000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic [1:0]  npc_op,
    input  logic        branch_taken,
    input  logic [31:0] ext_imm,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [15:0] imm16,
    output logic        fetch_err
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [1:0] NPC_SEQ    = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_JR     = 2'd3;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic        req_q;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_addr;
    logic [31:0] next_pc;

    // All additions are 32-bit and wrap naturally modulo 2^32.
    always_comb begin
        pc_plus4      = pc_q + 32'd4;
        branch_target = pc_plus4 + (ext_imm << 2);
        jump_target   = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        jr_addr       = jr_target & ~32'h0000_0003;
    end

    always_comb begin
        next_pc = pc_plus4;
        unique case (npc_op)
            NPC_SEQ:    next_pc = pc_plus4;
            NPC_BRANCH: next_pc = branch_taken ? branch_target : pc_plus4;
            NPC_JUMP:   next_pc = jump_target;
            NPC_JR:     next_pc = jr_addr;
        endcase
    end

    // imem_req and instr_valid are registered alongside the state so they
    // are glitch-free and already correct on the cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
        end else begin
            unique case (state)
                FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        state   <= HOLD;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                    end
                end
                HOLD: begin
                    // ack is not looked at here: no request is outstanding.
                    if (!stall) begin
                        pc_q    <= next_pc;
                        state   <= FETCH;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W     = (CNT_W_RAW < 8) ? 8 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] to_cnt;
    logic             err_q;

    // Counts consecutive FETCH cycles without ack; saturates at the limit
    // so the flag, once raised, is never re-triggered by wraparound.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else if (state == FETCH && !imem_ack) begin
            if (to_cnt != TO_LIMIT) begin
                to_cnt <= to_cnt + CNT_W'(1);
            end
            if (to_cnt == TO_LAST) begin
                err_q <= 1'b1;
            end
        end else begin
            to_cnt <= '0;
        end
    end

    assign fetch_err = err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |32'(TIMEOUT_CYCLES);
    assign fetch_err          = 1'b0;
`endif

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign imm16       = instr_q[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: scenario tasks with a fetch scoreboard
// (expected pc/instr pushed on ack, popped when instr_valid appears).

module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic [1:0]  npc_op;
    logic        branch_taken;
    logic [31:0] ext_imm;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic [15:0] imm16;
    logic        fetch_err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0] sb_pc[$];
    logic [31:0] sb_instr[$];

    instr_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .npc_op       (npc_op),
        .branch_taken (branch_taken),
        .ext_imm      (ext_imm),
        .jr_target    (jr_target),
        .pc           (pc),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .imm16        (imm16),
        .fetch_err    (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Serve one fetch at exp_pc after wait_cycles idle cycles, then check
    // the HOLD-state outputs against the scoreboard.
    task automatic fetch_one(input logic [31:0] rdata, input int wait_cycles,
                             input logic [31:0] exp_pc);
        logic [31:0] e_pc;
        logic [31:0] e_in;
        for (int i = 0; i < wait_cycles; i++) begin
            @(negedge clk);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
            errors++;
            $display("FAIL fetch_addr: req=%b addr=%h, want req=1 addr=%h",
                     imem_req, imem_addr, exp_pc);
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        sb_pc.push_back(exp_pc);
        sb_instr.push_back(rdata);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        checks++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL hold_flags: valid=%b req=%b, want valid=1 req=0",
                     instr_valid, imem_req);
        end else if (sb_pc.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: valid with empty queue");
        end else begin
            e_pc = sb_pc.pop_front();
            e_in = sb_instr.pop_front();
            checks++;
            if (pc !== e_pc || instr !== e_in || imm16 !== e_in[15:0]) begin
                errors++;
                $display("FAIL hold_data: pc=%h instr=%h imm16=%h, want %h %h %h",
                         pc, instr, imm16, e_pc, e_in, e_in[15:0]);
            end
        end
    endtask

    // Leave HOLD with the given next-PC selection and check the new fetch.
    task automatic advance(input logic [1:0] op, input logic taken,
                           input logic [31:0] imm, input logic [31:0] jr,
                           input logic [31:0] exp_next);
        stall        = 1'b0;
        npc_op       = op;
        branch_taken = taken;
        ext_imm      = imm;
        jr_target    = jr;
        @(negedge clk);
        npc_op       = 2'($urandom);
        branch_taken = 1'($urandom);
        ext_imm      = $urandom;
        jr_target    = $urandom;
        checks++;
        if (imem_req !== 1'b1 || instr_valid !== 1'b0 ||
            imem_addr !== exp_next || pc !== exp_next) begin
            errors++;
            $display("FAIL next_pc op=%0d: req=%b valid=%b addr=%h pc=%h, want addr %h",
                     op, imem_req, instr_valid, imem_addr, pc, exp_next);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (pc !== 32'h3000 || instr !== 32'h0 || instr_valid !== 1'b0 ||
            imem_req !== 1'b1 || imem_addr !== 32'h3000 || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: pc=%h instr=%h valid=%b req=%b addr=%h err=%b",
                     pc, instr, instr_valid, imem_req, imem_addr, fetch_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_first_fetch;
        fetch_one(32'h2008_0005, 0, 32'h3000);
        checks++;
        if (imm16 !== 16'h0005) begin
            errors++;
            $display("FAIL imm16: got %h want 0005", imm16);
        end
    endtask

    task automatic test_stall;
        stall      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (instr !== 32'h2008_0005 || pc !== 32'h3000 ||
                instr_valid !== 1'b1 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: instr=%h pc=%h valid=%b req=%b",
                         i, instr, pc, instr_valid, imem_req);
            end
        end
        imem_ack = 1'b0;
        advance(2'd0, 1'b0, 32'h0, 32'h0, 32'h3004);
    endtask

    task automatic test_branch;
        fetch_one(32'h1111_0001, 2, 32'h3004);
        advance(2'd0, 1'b0, 32'h0, 32'h0, 32'h3008);
        fetch_one(32'h1000_FFFE, 0, 32'h3008);
        advance(2'd1, 1'b1, 32'hFFFF_FFFE, 32'h0, 32'h3004);
        fetch_one(32'h2222_0002, 1, 32'h3004);
        advance(2'd0, 1'b0, 32'h0, 32'h0, 32'h3008);
        fetch_one(32'h1000_FFFE, 0, 32'h3008);
        advance(2'd1, 1'b0, 32'hFFFF_FFFE, 32'h0, 32'h300C);
        fetch_one(32'h3333_0003, 0, 32'h300C);
        advance(2'd0, 1'b1, 32'h0000_0010, 32'h0, 32'h3010);
    endtask

    task automatic test_jump_jr;
        fetch_one(32'h4444_0004, 0, 32'h3010);
        advance(2'd3, 1'b0, 32'h0, 32'h0000_3002, 32'h3000);
        fetch_one(32'h0800_0C10, 0, 32'h3000);
        advance(2'd2, 1'b0, 32'h0, 32'h0, 32'h0000_3040);
        fetch_one(32'h5555_0005, 0, 32'h3040);
        advance(2'd3, 1'b0, 32'h0, 32'h0000_1237, 32'h0000_1234);
        fetch_one(32'h6666_0006, 0, 32'h1234);
        advance(2'd3, 1'b0, 32'h0, 32'h7FFF_FFFC, 32'h7FFF_FFFC);
        fetch_one(32'h0BFF_FFFF, 0, 32'h7FFF_FFFC);
        advance(2'd2, 1'b0, 32'h0, 32'h0, 32'h8FFF_FFFC);
    endtask

    task automatic test_wrap;
        fetch_one(32'h7777_0007, 0, 32'h8FFF_FFFC);
        advance(2'd3, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
        fetch_one(32'h8888_0008, 0, 32'hFFFF_FFFC);
        advance(2'd0, 1'b0, 32'h0, 32'h0, 32'h0000_0000);
        fetch_one(32'h9999_0009, 0, 32'h0000_0000);
        advance(2'd1, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0000_0000);
    endtask

    task automatic test_back_to_back;
        int start;
        start = cyc;
        for (int i = 0; i < 4; i++) begin
            fetch_one(32'hA000_0000 + 32'(i), 0, 32'(i * 4));
            advance(2'd0, 1'b0, 32'h0, 32'h0, 32'(i * 4 + 4));
        end
        checks++;
        if (cyc - start !== 8) begin
            errors++;
            $display("FAIL back_to_back: %0d cycles, want 8", cyc - start);
        end
    endtask

    task automatic test_reset_mid_fetch;
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        rst      = 1'b0;
        imem_ack = 1'b0;
        checks++;
        if (instr !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b1 ||
            imem_addr !== 32'h3000) begin
            errors++;
            $display("FAIL reset_fetch: instr=%h valid=%b req=%b addr=%h",
                     instr, instr_valid, imem_req, imem_addr);
        end
        fetch_one(32'h1234_5678, 0, 32'h3000);
        rst       = 1'b1;
        stall     = 1'b0;
        npc_op    = 2'd3;
        jr_target = 32'h0000_8000;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (instr !== 32'h0 || instr_valid !== 1'b0 || pc !== 32'h3000) begin
            errors++;
            $display("FAIL reset_hold: instr=%h valid=%b pc=%h",
                     instr, instr_valid, pc);
        end
    endtask

    task automatic test_timeout;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        repeat (254) @(negedge clk);
        checks++;
        if (fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: err=%b want 0", fetch_err);
        end
        @(negedge clk);
        checks++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL timeout_hit: err=%b req=%b want 1 1", fetch_err, imem_req);
        end
        fetch_one(32'hBEEF_0001, 3, 32'h3000);
        advance(2'd0, 1'b0, 32'h0, 32'h0, 32'h3004);
        checks++;
        if (fetch_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: err=%b want 1", fetch_err);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: err=%b want 0", fetch_err);
        end
`else
        repeat (300) @(negedge clk);
        checks++;
        if (fetch_err !== 1'b0 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout: err=%b req=%b valid=%b", fetch_err,
                     imem_req, instr_valid);
        end
        fetch_one(32'hBEEF_0001, 0, 32'h3000);
`endif
    endtask

    initial begin
        rst          = 1'b1;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        stall        = 1'b0;
        npc_op       = 2'd0;
        branch_taken = 1'b0;
        ext_imm      = 32'h0;
        jr_target    = 32'h0;
        @(negedge clk);
        test_reset();
        test_first_fetch();
        test_stall();
        test_branch();
        test_jump_jr();
        test_wrap();
        test_back_to_back();
        test_reset_mid_fetch();
        test_timeout();
        checks++;
        if (sb_pc.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, want 0", sb_pc.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
